// File: rtl/regfile_write_arbiter.sv
// Register-file write port arbiter: round-robin between ALU and load writeback,
// with a 32-cycle sequence that zeroes every register.
module regfile_write_arbiter #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         Clear_Start_i,
    input  logic         Req0_Valid_i,
    input  logic [4:0]   Req0_Addr_i,
    input  logic [N-1:0] Req0_Data_i,
    output logic         Req0_Ready_o,
    input  logic         Req1_Valid_i,
    input  logic [4:0]   Req1_Addr_i,
    input  logic [N-1:0] Req1_Data_i,
    output logic         Req1_Ready_o,
    output logic         Reg_Write_o,
    output logic [4:0]   Write_Register_o,
    output logic [N-1:0] Write_Data_o,
    output logic         Clear_Busy_o
);

    typedef enum logic {
        RUN   = 1'b0,
        CLEAR = 1'b1
    } state_e;

    state_e       state_q, state_d;
    logic [4:0]   clr_cnt_q, clr_cnt_d;
    logic         favour1_q, favour1_d;
    logic         reg_write_q, reg_write_d;
    logic [4:0]   wr_addr_q, wr_addr_d;
    logic [N-1:0] wr_data_q, wr_data_d;
    logic         grant0, grant1;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        favour1_d   = favour1_q;
        reg_write_d = 1'b0;
        wr_addr_d   = '0;
        wr_data_d   = '0;
        grant0      = 1'b0;
        grant1      = 1'b0;

        unique case (state_q)
            RUN: begin
                if (Clear_Start_i) begin
                    // Clear wins over any pending request; address 0 is presented next cycle.
                    state_d     = CLEAR;
                    clr_cnt_d   = 5'd0;
                    reg_write_d = 1'b1;
                end else begin
                    grant1 = Req1_Valid_i && (!Req0_Valid_i || favour1_q);
                    grant0 = Req0_Valid_i && !grant1;
                    if (grant0) begin
                        favour1_d   = 1'b1;
                        reg_write_d = |Req0_Addr_i;
                        wr_addr_d   = Req0_Addr_i;
                        wr_data_d   = Req0_Data_i;
                    end else if (grant1) begin
                        favour1_d   = 1'b0;
                        reg_write_d = |Req1_Addr_i;
                        wr_addr_d   = Req1_Addr_i;
                        wr_data_d   = Req1_Data_i;
                    end
                end
            end
            CLEAR: begin
                // clr_cnt_q is the address being written this cycle; stop after 31.
                if (clr_cnt_q == 5'd31) begin
                    state_d   = RUN;
                    clr_cnt_d = 5'd0;
                end else begin
                    clr_cnt_d   = clr_cnt_q + 5'd1;
                    reg_write_d = 1'b1;
                    wr_addr_d   = clr_cnt_q + 5'd1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            clr_cnt_q   <= 5'd0;
            favour1_q   <= 1'b0;
            reg_write_q <= 1'b0;
            wr_addr_q   <= 5'd0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            favour1_q   <= favour1_d;
            reg_write_q <= reg_write_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    // Outputs are forced low for the whole time reset is held, not just after its first edge.
    assign Req0_Ready_o     = grant0 && !reset;
    assign Req1_Ready_o     = grant1 && !reset;
    assign Reg_Write_o      = reg_write_q && !reset;
    assign Write_Register_o = reset ? 5'd0 : wr_addr_q;
    assign Write_Data_o     = reset ? '0 : wr_data_q;
    assign Clear_Busy_o     = (state_q == CLEAR) && !reset;

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 32, meaning the data width of the register file write port.
REQ-002 The block SHALL have these ports:
 clk  input  1  single clock; all state updates on its rising edge
 reset  input  1  synchronous, active-high reset
 Clear_Start_i  input  1  request to zero all 32 registers
 Req0_Valid_i  input  1  requester 0 (ALU writeback) has a write pending
 Req0_Addr_i  input  5  requester 0 destination register
 Req0_Data_i  input  N  requester 0 write data
 Req0_Ready_o  output  1  requester 0 transfer accepted this cycle
 Req1_Valid_i  input  1  requester 1 (load writeback) has a write pending
 Req1_Addr_i  input  5  requester 1 destination register
 Req1_Data_i  input  N  requester 1 write data
 Req1_Ready_o  output  1  requester 1 transfer accepted this cycle
 Reg_Write_o  output  1  register file write enable
 Write_Register_o  output  5  register file write address
 Write_Data_o  output  N  register file write data
 Clear_Busy_o  output  1  clear sequence in progress
REQ-003 clk SHALL be the only clock, and reset SHALL be synchronous and active-high.

Function
REQ-004 The block SHALL have two states: RUN and CLEAR.
REQ-005 In RUN with Clear_Start_i low, Ready SHALL be combinational: at most one of Req0_Ready_o and Req1_Ready_o is high per cycle, and only for a requester whose Valid is high.
REQ-006 When exactly one Valid is high, that requester SHALL be granted.
REQ-007 When both Valids are high, the requester not granted on the most recent accepted transfer SHALL be granted (round-robin); after reset, requester 0 SHALL win the first tie.
REQ-008 The round-robin pointer SHALL update only on an accepted transfer (Valid and Ready both high at the edge).
REQ-009 An accepted transfer SHALL appear on Write_Register_o/Write_Data_o in the next cycle, for exactly one cycle, with Reg_Write_o = 1 (one-cycle latency). In a cycle with no transfer, Reg_Write_o SHALL be 0.
REQ-010 An accepted transfer with address 0 SHALL be acknowledged normally but SHALL produce Reg_Write_o = 0 (register 0 is never written by requesters).
REQ-011 Requesters SHALL hold Valid, Addr and Data stable until accepted; the arbiter SHALL NOT buffer unaccepted requests.
REQ-012 Clear_Start_i sampled high in RUN at edge k SHALL suppress both Readys in that cycle, with clear taking priority over any Valid.
REQ-013 For that clear sequence, cycles k+1 through k+32 SHALL present Reg_Write_o = 1, Write_Register_o = 0,1,...,31 in ascending order, and Write_Data_o = 0.
REQ-014 Clear_Busy_o SHALL be high exactly in cycles k+1 through k+32, and both Readys SHALL be low in those cycles.
REQ-015 Clear_Start_i asserted during CLEAR SHALL be ignored and SHALL NOT restart or extend the sequence.
REQ-016 The state SHALL return to RUN after the address-31 write, so that the first handshake can occur in cycle k+33.
REQ-017 The 5-bit clear counter SHALL NOT wrap into a second pass.

Reset
REQ-018 While reset is high, all outputs SHALL be 0, the state SHALL be RUN, the clear counter SHALL be 0, and the round-robin pointer SHALL favour requester 0.
REQ-019 Reset asserted during CLEAR SHALL abort the sequence: the next cycle shows Clear_Busy_o = 0 and Reg_Write_o = 0, and no resumption occurs.
REQ-020 reset SHALL take priority over Clear_Start_i and over all Valids.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
 - Single requester: Req0 valid, addr 5, data 0xDEADBEEF -> Req0_Ready_o high the same cycle; next cycle Reg_Write_o = 1, addr 5, data 0xDEADBEEF.
 - Tie after reset: both valid for 4 cycles, Req0 addr 1, Req1 addr 2 -> grants alternate 0,1,0,1; outputs alternate addr 1,2,1,2.
 - Address 0: Req1 valid, addr 0, data 0x12345678 -> Req1_Ready_o high; next cycle Reg_Write_o = 0.
 - Clear with contention: Clear_Start_i pulsed while both valid -> no Ready for 33 cycles; 32 writes to addr 0..31 with data 0; Clear_Busy_o high for 32 cycles; Req0 is granted in cycle k+33.
 - Reset mid-clear: reset asserted at clear cycle 10 -> Clear_Busy_o = 0 and Reg_Write_o = 0 the next cycle; after release, a tie grants Req0.
 - Assertions throughout: both Readys never high together; Reg_Write_o never high for a requester address of 0.
